// File: rtl/psx_pkg.sv
// Shared PSX pad-link constants and state encodings, used by both the
// console-side master and the pad-side responder.
package psx_pkg;

    localparam logic [7:0] START_CMD      = 8'h01;
    localparam logic [7:0] BEGIN_TX_CMD   = 8'h42;
    localparam logic [7:0] PREAMBLE       = 8'h5A;
    localparam logic [7:0] PAD_ID_DIGITAL = 8'h41;
    localparam logic [7:0] PAD_ID_ANALOG  = 8'h73;
    localparam logic [7:0] IDLE_REPLY     = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_DONE   = 2'd2,
        ST_IGNORE = 2'd3
    } psx_state_t;

endpackage

// File: rtl/psx_sync_edge.sv
// Multi-stage synchronizer for one asynchronous link line, with single-cycle
// rise/fall pulses derived from the synchronized level. All flops reset to 1.
module psx_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= '1;
            prev_reg <= 1'b1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign sync_out = sync_reg[SYNC_STAGES-1];
    assign rise     = sync_reg[SYNC_STAGES-1] & ~prev_reg;
    assign fall     = ~sync_reg[SYNC_STAGES-1] & prev_reg;

endmodule

// File: rtl/psx_pad_responder.sv
// Pad side of the PSX controller link: answers the 0x01/0x42 poll with ID,
// 0x5A and a button snapshot. Define PSX_PAD_ANALOG_EN for the 9-byte analog reply.
module psx_pad_responder
    import psx_pkg::*;
#(
    parameter int ACK_DELAY   = 16,
    parameter int ACK_WIDTH   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        psx_clk,
    input  logic        cmd,
    input  logic        att,
    input  logic [15:0] buttons,
    input  logic [31:0] analog,
    output logic        data,
    output logic        ack,
    output logic [7:0]  rx_byte,
    output logic        poll_done
);

`ifdef PSX_PAD_ANALOG_EN
    localparam logic [7:0] PAD_ID  = PAD_ID_ANALOG;
    localparam int         N_BYTES = 9;
`else
    localparam logic [7:0] PAD_ID  = PAD_ID_DIGITAL;
    localparam int         N_BYTES = 5;
`endif
    localparam logic [3:0] LAST_IDX = 4'(N_BYTES - 1);
    localparam int         CW       = $clog2(ACK_DELAY + ACK_WIDTH + 1);

    // Lane 0 = psx_clk, lane 1 = cmd, lane 2 = att
    logic [2:0] raw_in, lvl, rise_p, fall_p;
    assign raw_in = {att, cmd, psx_clk};

    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
        psx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk      (clk),
            .rst      (rst),
            .din      (raw_in[gi]),
            .sync_out (lvl[gi]),
            .rise     (rise_p[gi]),
            .fall     (fall_p[gi])
        );
    end

    logic clk_rise, clk_fall, cmd_s, att_rise, att_fall;
    assign clk_rise = rise_p[0];
    assign clk_fall = fall_p[0];
    assign cmd_s    = lvl[1];
    assign att_rise = rise_p[2];
    assign att_fall = fall_p[2];

    logic unused_sync;
    assign unused_sync = ^{lvl[2], lvl[0], rise_p[1], fall_p[1]};

    psx_state_t    state_reg, state_next;
    logic [3:0]    byte_idx_reg, byte_idx_next;
    logic [2:0]    bit_cnt_reg, bit_cnt_next;
    logic [7:0]    rx_shift_reg, rx_shift_next;
    logic [7:0]    rx_byte_reg, rx_byte_next;
    logic [15:0]   btn_snap_reg, btn_snap_next;
    logic          data_reg, data_next;
    logic          ack_reg, ack_next;
    logic          done_reg, done_next;
    logic          pend_reg, pend_next;
    logic          act_reg, act_next;
    logic [CW-1:0] delay_cnt_reg, delay_cnt_next;
    logic [CW-1:0] width_cnt_reg, width_cnt_next;
    logic [7:0]    tx_byte, rx_full;

`ifdef PSX_PAD_ANALOG_EN
    logic [31:0] ana_snap_reg, ana_snap_next;
`else
    logic unused_analog;
    assign unused_analog = ^analog;
`endif

    always_comb begin
        tx_byte = IDLE_REPLY;
        case (byte_idx_reg)
            4'd0: tx_byte = IDLE_REPLY;
            4'd1: tx_byte = PAD_ID;
            4'd2: tx_byte = PREAMBLE;
            4'd3: tx_byte = btn_snap_reg[7:0];
            4'd4: tx_byte = btn_snap_reg[15:8];
`ifdef PSX_PAD_ANALOG_EN
            4'd5: tx_byte = ana_snap_reg[7:0];
            4'd6: tx_byte = ana_snap_reg[15:8];
            4'd7: tx_byte = ana_snap_reg[23:16];
            4'd8: tx_byte = ana_snap_reg[31:24];
`endif
            default: tx_byte = IDLE_REPLY;
        endcase
    end

    assign rx_full = {cmd_s, rx_shift_reg[6:0]};

    always_comb begin
        state_next     = state_reg;
        byte_idx_next  = byte_idx_reg;
        bit_cnt_next   = bit_cnt_reg;
        rx_shift_next  = rx_shift_reg;
        rx_byte_next   = rx_byte_reg;
        btn_snap_next  = btn_snap_reg;
        data_next      = data_reg;
        ack_next       = ack_reg;
        done_next      = 1'b0;
        pend_next      = pend_reg;
        act_next       = act_reg;
        delay_cnt_next = delay_cnt_reg;
        width_cnt_next = width_cnt_reg;
`ifdef PSX_PAD_ANALOG_EN
        ana_snap_next  = ana_snap_reg;
`endif

        if (att_rise) begin
            // Deselect aborts everything except the last received byte
            state_next     = ST_IDLE;
            bit_cnt_next   = '0;
            data_next      = 1'b1;
            ack_next       = 1'b1;
            pend_next      = 1'b0;
            act_next       = 1'b0;
            delay_cnt_next = '0;
            width_cnt_next = '0;
        end else begin
            if (pend_reg) begin
                if (clk_fall) begin
                    pend_next = 1'b0;
                end else if (delay_cnt_reg == '0) begin
                    pend_next      = 1'b0;
                    act_next       = 1'b1;
                    ack_next       = 1'b0;
                    width_cnt_next = CW'(ACK_WIDTH - 1);
                end else begin
                    delay_cnt_next = delay_cnt_reg - 1'b1;
                end
            end else if (act_reg) begin
                if (width_cnt_reg == '0) begin
                    act_next = 1'b0;
                    ack_next = 1'b1;
                end else begin
                    width_cnt_next = width_cnt_reg - 1'b1;
                end
            end

            case (state_reg)
                ST_IDLE: begin
                    data_next = 1'b1;
                    if (att_fall) begin
                        btn_snap_next = buttons;
`ifdef PSX_PAD_ANALOG_EN
                        ana_snap_next = analog;
`endif
                        byte_idx_next = '0;
                        bit_cnt_next  = '0;
                        state_next    = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (clk_fall) begin
                        data_next = tx_byte[bit_cnt_reg];
                    end
                    if (clk_rise) begin
                        rx_shift_next[bit_cnt_reg] = cmd_s;
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                        if (bit_cnt_reg == 3'd7) begin
                            rx_byte_next = rx_full;
                            bit_cnt_next = '0;
                            if ((byte_idx_reg == 4'd0 && rx_full != START_CMD) ||
                                (byte_idx_reg == 4'd1 && rx_full != BEGIN_TX_CMD)) begin
                                state_next = ST_IGNORE;
                                data_next  = 1'b1;
                            end else if (byte_idx_reg == LAST_IDX) begin
                                state_next = ST_DONE;
                                data_next  = 1'b1;
                                done_next  = 1'b1;
                            end else begin
                                // Delay counts from the cycle that registers the final rising edge
                                pend_next      = 1'b1;
                                delay_cnt_next = CW'(ACK_DELAY - 1);
                                byte_idx_next  = byte_idx_reg + 1'b1;
                            end
                        end
                    end
                end
                ST_DONE, ST_IGNORE: begin
                    data_next = 1'b1;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            byte_idx_reg  <= '0;
            bit_cnt_reg   <= '0;
            rx_shift_reg  <= '0;
            rx_byte_reg   <= '0;
            btn_snap_reg  <= '1;
            data_reg      <= 1'b1;
            ack_reg       <= 1'b1;
            done_reg      <= 1'b0;
            pend_reg      <= 1'b0;
            act_reg       <= 1'b0;
            delay_cnt_reg <= '0;
            width_cnt_reg <= '0;
`ifdef PSX_PAD_ANALOG_EN
            ana_snap_reg  <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            byte_idx_reg  <= byte_idx_next;
            bit_cnt_reg   <= bit_cnt_next;
            rx_shift_reg  <= rx_shift_next;
            rx_byte_reg   <= rx_byte_next;
            btn_snap_reg  <= btn_snap_next;
            data_reg      <= data_next;
            ack_reg       <= ack_next;
            done_reg      <= done_next;
            pend_reg      <= pend_next;
            act_reg       <= act_next;
            delay_cnt_reg <= delay_cnt_next;
            width_cnt_reg <= width_cnt_next;
`ifdef PSX_PAD_ANALOG_EN
            ana_snap_reg  <= ana_snap_next;
`endif
        end
    end

    assign data      = data_reg;
    assign ack       = ack_reg;
    assign rx_byte   = rx_byte_reg;
    assign poll_done = done_reg;

endmodule

// File: tb/tb_psx_pad_responder.sv
// Directed bench for psx_pad_responder: a table of full polls plus hand-written
// abort, reset, snapshot and early-clock sequences.
module tb_psx_pad_responder;
    import psx_pkg::*;

    localparam int SYNC_STAGES = 2;
    localparam int ACK_DELAY   = 16;
    localparam int ACK_WIDTH   = 8;
    localparam int H           = 8;   // clk cycles per psx_clk half period
    localparam int GAP         = 32;  // clk cycles between bytes
    // Input edge reaches the FSM SYNC_STAGES+1 posedges after it is driven
    localparam int ACK_LAT     = SYNC_STAGES + 1 + ACK_DELAY;
    localparam int DONE_LAT    = SYNC_STAGES + 1;
    localparam logic [31:0] ANALOG_VAL = 32'h80807F7F;
`ifdef PSX_PAD_ANALOG_EN
    localparam int         NB = 9;
    localparam logic [7:0] ID = 8'h73;
`else
    localparam int         NB = 5;
    localparam logic [7:0] ID = 8'h41;
`endif

    logic        clk, rst, psx_clk, cmd, att;
    logic [15:0] buttons;
    logic [31:0] analog;
    logic        data, ack, poll_done;
    logic [7:0]  rx_byte;

    psx_pad_responder #(
        .ACK_DELAY   (ACK_DELAY),
        .ACK_WIDTH   (ACK_WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .psx_clk   (psx_clk),
        .cmd       (cmd),
        .att       (att),
        .buttons   (buttons),
        .analog    (analog),
        .data      (data),
        .ack       (ack),
        .rx_byte   (rx_byte),
        .poll_done (poll_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int   ack_pulses  = 0;
    int   done_cycles = 0;
    logic ack_q       = 1'b1;
    always @(negedge clk) begin
        if (ack_q === 1'b1 && ack === 1'b0) ack_pulses++;
        ack_q = ack;
        if (poll_done === 1'b1) done_cycles++;
    end

    typedef struct {
        logic [7:0]  c0;
        logic [7:0]  c1;
        logic [7:0]  tail;
        logic [15:0] btn;
        logic [7:0]  exp_rx;
        int          exp_acks;
        int          exp_done;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    function automatic logic [7:0] model_tx(input int j, input logic [15:0] btn);
        logic [31:0] a;
        a = ANALOG_VAL;
        case (j)
            0: return 8'hFF;
            1: return ID;
            2: return 8'h5A;
            3: return btn[7:0];
            4: return btn[15:8];
            5: return a[7:0];
            6: return a[15:8];
            7: return a[23:16];
            8: return a[31:24];
            default: return 8'hFF;
        endcase
    endfunction

    task automatic poll_begin();
        @(negedge clk);
        att = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic poll_end();
        @(negedge clk);
        att = 1'b1;
        psx_clk = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] tx, input int gap, output logic [7:0] rx,
                             output int a_start, output int a_len, output int d_at);
        a_start = -1;
        a_len   = 0;
        d_at    = -1;
        rx      = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            psx_clk = 1'b0;
            cmd     = tx[i];
            repeat (H) @(negedge clk);
            rx[i]   = data;
            psx_clk = 1'b1;
            if (i < 7) repeat (H - 1) @(negedge clk);
        end
        for (int k = 1; k <= gap; k++) begin
            @(negedge clk);
            if (ack === 1'b0) begin
                if (a_start < 0) a_start = k;
                a_len++;
            end
            if (poll_done === 1'b1 && d_at < 0) d_at = k;
        end
    endtask

    task automatic run_poll(input string tag, input vec_t v, input int early_after,
                            input logic chg_btn, input logic [15:0] new_btn);
        logic [7:0] rx, c, exp_b;
        int   as, al, da, gap, ack_base, done_base;
        logic ok0, ok1, exp_ack;
        ok0       = (v.c0 == 8'h01);
        ok1       = ok0 && (v.c1 == 8'h42);
        buttons   = v.btn;
        analog    = ANALOG_VAL;
        ack_base  = ack_pulses;
        done_base = done_cycles;
        poll_begin();
        for (int j = 0; j < NB; j++) begin
            c   = (j == 0) ? v.c0 : (j == 1) ? v.c1 : v.tail;
            gap = (j == early_after) ? 5 : GAP;
            send_byte(c, gap, rx, as, al, da);
            exp_b = model_tx(j, v.btn);
            if (j >= 1 && !ok0) exp_b = 8'hFF;
            if (j >= 2 && !ok1) exp_b = 8'hFF;
            check($sformatf("%s byte%0d data", tag, j), 32'(rx), 32'(exp_b));
            exp_ack = (j < NB - 1) && ((j == 0) ? ok0 : ok1) && (j != early_after);
            if (exp_ack) begin
                check($sformatf("%s byte%0d ack_start", tag, j), 32'(as), 32'(ACK_LAT));
                check($sformatf("%s byte%0d ack_len", tag, j), 32'(al), 32'(ACK_WIDTH));
            end else begin
                check($sformatf("%s byte%0d no_ack", tag, j), 32'(as), 32'(-1));
            end
            if (j == NB - 1)
                check($sformatf("%s done_at", tag), 32'(da), ok1 ? 32'(DONE_LAT) : 32'(-1));
            if (j == 1 && chg_btn) buttons = new_btn;
        end
        check({tag, " state_end"}, 32'(dut.state_reg), ok1 ? 32'(ST_DONE) : 32'(ST_IGNORE));
        check({tag, " ack_pulses"}, 32'(ack_pulses - ack_base), 32'(v.exp_acks));
        check({tag, " done_cycles"}, 32'(done_cycles - done_base), 32'(v.exp_done));
        check({tag, " rx_byte"}, 32'(rx_byte), 32'(v.exp_rx));
        poll_end();
        check({tag, " state_idle"}, 32'(dut.state_reg), 32'(ST_IDLE));
    endtask

    vec_t vecs[5];

    initial begin
        logic [7:0] rx;
        int as, al, da;

        vecs[0] = '{8'h01, 8'h42, 8'h00, 16'hFFFE, 8'h00, NB - 1, 1};
        vecs[1] = '{8'h81, 8'h81, 8'h81, 16'hFFFE, 8'h81, 0,      0};
        vecs[2] = '{8'h01, 8'h43, 8'h43, 16'hFFFE, 8'h43, 1,      0};
        vecs[3] = '{8'h01, 8'h42, 8'hA5, 16'h1234, 8'hA5, NB - 1, 1};
        vecs[4] = '{8'h01, 8'h42, 8'h3C, 16'h0000, 8'h3C, NB - 1, 1};

        rst = 1'b1; psx_clk = 1'b1; cmd = 1'b1; att = 1'b1;
        buttons = 16'hFFFF; analog = ANALOG_VAL;
        #1;
        check("reset data", 32'(data), 32'd1);
        check("reset ack", 32'(ack), 32'd1);
        check("reset rx_byte", 32'(rx_byte), 32'h00);
        check("reset poll_done", 32'(poll_done), 32'd0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        for (int t = 0; t < 5; t++)
            run_poll($sformatf("vec%0d", t), vecs[t], -1, 1'b0, 16'h0000);

        // Snapshot: buttons change mid-poll
        run_poll("snap", vecs[0], -1, 1'b1, 16'h0000);

        // Early clock: byte 2 starts 5 cycles after byte 1 ends
        begin
            vec_t v;
            v = vecs[0];
            v.exp_acks = NB - 2;
            run_poll("early", v, 1, 1'b0, 16'h0000);
        end

        // Deselect after 3 bits of byte 3, while data is low
        buttons = 16'h0000;
        poll_begin();
        send_byte(8'h01, GAP, rx, as, al, da);
        send_byte(8'h42, GAP, rx, as, al, da);
        send_byte(8'h00, GAP, rx, as, al, da);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); psx_clk = 1'b0; cmd = 1'b0;
            repeat (H) @(negedge clk); psx_clk = 1'b1;
            repeat (H - 1) @(negedge clk);
        end
        check("abort data_before", 32'(data), 32'd0);
        @(negedge clk);
        att = 1'b1;
        repeat (SYNC_STAGES + 1) @(negedge clk);
        check("abort data", 32'(data), 32'd1);
        check("abort ack", 32'(ack), 32'd1);
        check("abort state", 32'(dut.state_reg), 32'(ST_IDLE));
        repeat (8) @(negedge clk);

        // Deselect while an ack pulse is low
        poll_begin();
        send_byte(8'h01, ACK_LAT + 1, rx, as, al, da);
        check("ackabort low_before", 32'(ack), 32'd0);
        @(negedge clk);
        att = 1'b1;
        repeat (SYNC_STAGES + 1) @(negedge clk);
        check("ackabort ack", 32'(ack), 32'd1);
        check("ackabort state", 32'(dut.state_reg), 32'(ST_IDLE));
        repeat (8) @(negedge clk);
        run_poll("after_abort", vecs[0], -1, 1'b0, 16'h0000);

        // Asynchronous reset mid-byte
        buttons = 16'hFFFE;
        poll_begin();
        send_byte(8'h01, GAP, rx, as, al, da);
        send_byte(8'h42, GAP, rx, as, al, da);
        @(negedge clk); psx_clk = 1'b0; cmd = 1'b0;
        repeat (H) @(negedge clk);
        check("rstmid data_before", 32'(data), 32'd0);
        check("rstmid rx_before", 32'(rx_byte), 32'h42);
        rst = 1'b1;
        #1;
        check("rstmid data", 32'(data), 32'd1);
        check("rstmid ack", 32'(ack), 32'd1);
        check("rstmid rx_byte", 32'(rx_byte), 32'h00);
        check("rstmid state", 32'(dut.state_reg), 32'(ST_IDLE));
        @(negedge clk);
        psx_clk = 1'b1; att = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        run_poll("after_rst", vecs[3], -1, 1'b0, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
